// File: rtl/seg7_scan4.sv
// Four-digit multiplexed common-anode seven-segment driver with held BCD digits,
// per-digit decimal points, leading-zero blanking and an anti-ghost blank cycle per slot.
module seg7_scan4 #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] dp,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);

  logic [3:0]    h_a_q, h_a_d, h_b_q, h_b_d, h_c_q, h_c_d, h_d_q, h_d_d;
  logic [3:0]    hdp_q, hdp_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_tick_q, frame_tick_d;

  logic          tc;
  logic [3:0]    sel_dig;
  logic [3:0]    sel_an;
  logic          sel_dp;
  logic          sel_lz;
  logic          z_a, z_ab, z_abc;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    h_a_d = h_a_q;
    h_b_d = h_b_q;
    h_c_d = h_c_q;
    h_d_d = h_d_q;
    hdp_d = hdp_q;
    if (load) begin
      h_a_d = A;
      h_b_d = B;
      h_c_d = C;
      h_d_d = D;
      hdp_d = dp;
    end

    tc     = (pcnt_q == PTERM);
    pcnt_d = tc ? '0 : pcnt_q + PW'(1);
    idx_d  = tc ? idx_q + 2'd1 : idx_q;

    // Leading-zero chain: a digit is blankable only if it and all digits left of it are 0
    z_a   = (h_a_q == 4'd0);
    z_ab  = z_a && (h_b_q == 4'd0);
    z_abc = z_ab && (h_c_q == 4'd0);

    sel_dig = h_a_q;
    sel_an  = 4'b0111;
    sel_dp  = hdp_q[3];
    sel_lz  = z_a;
    case (idx_q)
      2'd0: begin sel_dig = h_a_q; sel_an = 4'b0111; sel_dp = hdp_q[3]; sel_lz = z_a;   end
      2'd1: begin sel_dig = h_b_q; sel_an = 4'b1011; sel_dp = hdp_q[2]; sel_lz = z_ab;  end
      2'd2: begin sel_dig = h_c_q; sel_an = 4'b1101; sel_dp = hdp_q[1]; sel_lz = z_abc; end
      default: begin sel_dig = h_d_q; sel_an = 4'b1110; sel_dp = hdp_q[0]; sel_lz = 1'b0; end
    endcase

    an_d         = (pcnt_q == '0) ? 4'b1111 : sel_an;
    seg_d        = ((BLANK_LZ != 0) && sel_lz) ? 7'h7F : decode(sel_dig);
    dp_n_d       = ~sel_dp;
    frame_tick_d = tc && (idx_q == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_a_q        <= '0;
      h_b_q        <= '0;
      h_c_q        <= '0;
      h_d_q        <= '0;
      hdp_q        <= '0;
      pcnt_q       <= '0;
      idx_q        <= '0;
      an_q         <= 4'b1111;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      h_a_q        <= h_a_d;
      h_b_q        <= h_b_d;
      h_c_q        <= h_c_d;
      h_d_q        <= h_d_d;
      hdp_q        <= hdp_d;
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Directed bench for seg7_scan4 (PRESCALE=4): scoreboard of per-cycle expected outputs
// from a behavioural model, plus constant-table checks of whole frames.
module tb_seg7_scan4;
  localparam int unsigned PS = 4;

  logic       clk = 1'b0;
  logic       rst, load;
  logic [3:0] A, B, C, D, dp;
  logic [3:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  logic       dp_n, dp_n_nb, ft, ft_nb;

  seg7_scan4 #(.PRESCALE(PS), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .load(load), .A(A), .B(B), .C(C), .D(D), .dp(dp),
    .an(an), .seg(seg), .dp_n(dp_n), .frame_tick(ft));

  seg7_scan4 #(.PRESCALE(PS), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .A(A), .B(B), .C(C), .D(D), .dp(dp),
    .an(an_nb), .seg(seg_nb), .dp_n(dp_n_nb), .frame_tick(ft_nb));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_nb;
    logic       dp_n;
    logic       ft;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_pcnt, m_idx;
  logic [3:0] m_h[4];
  logic [3:0] m_dp;
  int   since_tick;
  bit   tick_seen;
  int   n_ticks = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
      4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
      4'd8: return 7'h00;  4'd9: return 7'h10;  default: return 7'h3F;
    endcase
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [3:0] an_tab[4];
    bit lead;
    an_tab = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    lead = 1'b1;
    for (int j = 0; j <= m_idx; j++) if (m_h[j] != 4'd0) lead = 1'b0;
    e.an     = (m_pcnt == 0) ? 4'b1111 : an_tab[m_idx];
    e.seg_nb = seg_of(m_h[m_idx]);
    e.seg    = (lead && m_idx != 3) ? 7'h7F : e.seg_nb;
    e.dp_n   = ~m_dp[3-m_idx];
    e.ft     = (m_idx == 3 && m_pcnt == PS - 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pcnt = 0;
    m_idx  = 0;
    for (int j = 0; j < 4; j++) m_h[j] = 4'd0;
    m_dp = 4'd0;
    sb_q.delete();
    tick_seen  = 1'b0;
    since_tick = 0;
  endtask

  task automatic set_in(input logic [3:0] a, b, c, d, dpv);
    A = a; B = b; C = c; D = d; dp = dpv;
  endtask

  // One clock: predict from pre-edge model state, advance model, compare #1 after the edge
  task automatic step(input bit ld);
    exp_t e;
    load = ld;
    @(posedge clk);
    sb_q.push_back(predict());
    if (ld) begin
      m_h[0] = A; m_h[1] = B; m_h[2] = C; m_h[3] = D; m_dp = dp;
    end
    if (m_pcnt == PS - 1) begin
      m_pcnt = 0;
      m_idx  = (m_idx + 1) % 4;
    end else begin
      m_pcnt++;
    end
    #1;
    e = sb_q.pop_front();
    chk("an",     16'(an),      16'(e.an));
    chk("seg",    16'(seg),     16'(e.seg));
    chk("seg_nb", 16'(seg_nb),  16'(e.seg_nb));
    chk("dp_n",   16'(dp_n),    16'(e.dp_n));
    chk("ft",     16'(ft),      16'(e.ft));
    since_tick++;
    if (ft) begin
      n_ticks++;
      if (tick_seen) chk("tick_gap", 16'(since_tick), 16'(4 * PS));
      tick_seen  = 1'b1;
      since_tick = 0;
    end
    load = 1'b0;
  endtask

  task automatic do_reset_pulse();
    rst = 1'b1;
    #1;
    chk("rst_an",   16'(an),    16'h000F);
    chk("rst_seg",  16'(seg),   16'h007F);
    chk("rst_dpn",  16'(dp_n),  16'h0001);
    chk("rst_ft",   16'(ft),    16'h0000);
    chk("rst_an2",  16'(an_nb), 16'h000F);
    chk("rst_seg2", 16'(seg_nb), 16'h007F);
    rst = 1'b0;
    model_reset();
  endtask

  // Align to slot A then check a full frame against constant tables
  task automatic frame(input string nm, input logic [27:0] es, input logic [27:0] enb,
                       input logic [3:0] edpn);
    logic [3:0] an_tab[4];
    an_tab = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    for (int k = 0; k < 4 * PS; k++) begin
      if (m_pcnt == 0 && m_idx == 0) break;
      step(1'b0);
    end
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < PS; p++) begin
        step(1'b0);
        chk({nm, "_an"}, 16'(an), (p == 0) ? 16'h000F : 16'(an_tab[s]));
        if (p == 1) begin
          chk({nm, "_seg"},   16'(seg),    16'(es[27-7*s -: 7]));
          chk({nm, "_segnb"}, 16'(seg_nb), 16'(enb[27-7*s -: 7]));
          chk({nm, "_dpn"},   16'(dp_n),   16'(edpn[3-s]));
        end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b1;
    set_in(4'd9, 4'd9, 4'd9, 4'd9, 4'hF);
    #1;
    chk("init_an",  16'(an),   16'h000F);
    chk("init_seg", 16'(seg),  16'h007F);
    chk("init_dpn", 16'(dp_n), 16'h0001);
    chk("init_ft",  16'(ft),   16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("hold_an",  16'(an),  16'h000F);
    chk("hold_seg", 16'(seg), 16'h007F);
    rst  = 1'b0;
    load = 1'b0;
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    model_reset();

    // Held digits all zero (load during reset ignored): A,B,C blank, D shows 0
    frame("f0", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    set_in(4'd6, 4'd0, 4'd3, 4'd1, 4'b0000);
    step(1'b1);
    frame("f6031", {7'h02, 7'h40, 7'h30, 7'h79}, {7'h02, 7'h40, 7'h30, 7'h79}, 4'b1111);

    set_in(4'd0, 4'd0, 4'd4, 4'd2, 4'b0000);
    step(1'b1);
    frame("f0042", {7'h7F, 7'h7F, 7'h19, 7'h24}, {7'h40, 7'h40, 7'h19, 7'h24}, 4'b1111);

    set_in(4'd0, 4'd0, 4'd4, 4'hC, 4'b0100);
    step(1'b1);
    frame("fdash", {7'h7F, 7'h7F, 7'h19, 7'h3F}, {7'h40, 7'h40, 7'h19, 7'h3F}, 4'b1011);

    // Back-to-back loads: last wins
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    step(1'b1);
    set_in(4'd5, 4'd6, 4'd7, 4'd8, 4'b1000);
    step(1'b1);
    frame("fb2b", {7'h12, 7'h02, 7'h78, 7'h00}, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0111);

    // Load coinciding with terminal count
    for (int k = 0; k < PS; k++) begin
      if (m_pcnt == PS - 1) break;
      step(1'b0);
    end
    set_in(4'd9, 4'd9, 4'd9, 4'd9, 4'b0000);
    step(1'b1);
    step(1'b0);
    chk("tc_blank_an", 16'(an), 16'h000F);
    step(1'b0);
    chk("tc_new_seg", 16'(seg), 16'h0010);

    for (int k = 0; k < 10 * PS; k++) step(1'b0);

    // Asynchronous reset mid-slot
    for (int k = 0; k < PS; k++) begin
      if (m_pcnt == 2) break;
      step(1'b0);
    end
    do_reset_pulse();
    frame("frst", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    chk("ticks_seen", 16'(n_ticks >= 4), 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout total=%0d bad=%0d", total, bad);
  end
endmodule
